// File: rtl/fdiv_issue_ctrl.sv
// Purpose: issues tagged divide requests to a fixed-latency FPU pipe and returns results in issue order.
// Latency: a request issued at cycle t presents res_valid at t+LAT+1 (empty FIFO); one op per cycle.
// Backpressure: credit-based; req_ready drops once in-flight plus buffered results reach DEPTH.
//
// Ports
//   i_sys_clk, i_rst        clock, synchronous active-low reset
//   i_req_* / o_req_ready   tagged request (x1 / x2 / tag), valid/ready
//   o_div_*                 drive the unit's stage1_valid, x1, x2 (pass-through of the request)
//   i_div_*                 unit out_valid, y, ovf, unf
//   o_res_* / i_res_ready   head of the result FIFO (y, ovf, unf, tag), valid/ready
//   o_busy                  ops in flight, results buffered, or post-reset drain active
//   o_err_sticky            unit out_valid disagreed with the tag pipe; cleared only by reset
module fdiv_issue_ctrl #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [31:0]      i_req_x1,
  input  logic [31:0]      i_req_x2,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_div_valid,
  output logic [31:0]      o_div_x1,
  output logic [31:0]      o_div_x2,
  input  logic             i_div_out_valid,
  input  logic [31:0]      i_div_y,
  input  logic             i_div_ovf,
  input  logic             i_div_unf,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [31:0]      o_res_y,
  output logic             o_res_ovf,
  output logic             o_res_unf,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_busy,
  output logic             o_err_sticky
);

  localparam int CW = $clog2(DEPTH + 1);  // occupancy / credit counters
  localparam int PW = $clog2(DEPTH);      // FIFO pointers, wrap naturally (DEPTH is 2^PW)
  localparam int DW = $clog2(LAT + 1);    // post-reset drain counter

  typedef struct packed {
    logic [31:0]      y;
    logic             ovf;
    logic             unf;
    logic [TAG_W-1:0] tag;
  } res_t;

  // State
  logic [CW-1:0]    r_inflight;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [DW-1:0]    r_drain;
  logic [LAT-1:0]   r_tp_v;
  logic [TAG_W-1:0] r_tp_tag [LAT];
  res_t             r_mem    [DEPTH];
  logic             r_err;

  // Combinational
  logic             w_draining;
  logic [CW-1:0]    w_credit;
  logic             w_issue;
  logic             w_last_v;
  logic [TAG_W-1:0] w_last_tag;
  logic             w_push;
  logic             w_pop;
  res_t             w_wr_ent;
  res_t             w_head;

  // ---------------------------------------------------------------------------
  // Issue side. The unit has no stall input, so a result slot must be reserved
  // before issuing: every op in flight or sitting in the FIFO consumes a credit.
  // ---------------------------------------------------------------------------
  assign w_draining  = (r_drain != '0);
  assign w_credit    = CW'(DEPTH) - r_inflight - r_count;
  assign o_req_ready = (w_credit != '0) && !w_draining;
  assign w_issue     = i_req_valid && o_req_ready;

  assign o_div_valid = w_issue;
  assign o_div_x1    = i_req_x1;
  assign o_div_x2    = i_req_x2;

  // The unit's pipeline registers are not reset, so stale out_valids may emerge
  // for up to LAT cycles after reset; hold everything off until they are gone.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      r_drain <= DW'(LAT);
    end else if (w_draining) begin
      r_drain <= r_drain - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe: mirrors the unit pipeline so its last stage lines up with the
  // unit's out_valid. Valid bits are reset; tags only matter alongside them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      r_tp_v <= '0;
    end else begin
      r_tp_v <= {r_tp_v[LAT-2:0], w_issue};
    end
  end

  always_ff @(posedge i_sys_clk) begin
    r_tp_tag[0] <= i_req_tag;
    for (int k = 1; k < LAT; k++) begin
      r_tp_tag[k] <= r_tp_tag[k-1];
    end
  end

  assign w_last_v   = r_tp_v[LAT-1];
  assign w_last_tag = r_tp_tag[LAT-1];

  // A result is accepted only when both the unit and the tag pipe agree; a
  // spurious out_valid is flagged but never written.
  assign w_push = i_div_out_valid && w_last_v && !w_draining;

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      r_err <= 1'b0;
    end else if (!w_draining && (i_div_out_valid != w_last_v)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err_sticky = r_err;

  // In-flight count: incremented on issue, decremented when the result lands.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO: show-ahead read of registered storage. count tells full from
  // empty since the pointers alone cannot.
  // ---------------------------------------------------------------------------
  assign w_wr_ent.y   = i_div_y;
  assign w_wr_ent.ovf = i_div_ovf;
  assign w_wr_ent.unf = i_div_unf;
  assign w_wr_ent.tag = w_last_tag;

  assign o_res_valid = (r_count != '0);
  assign w_pop       = o_res_valid && i_res_ready;

  always_ff @(posedge i_sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_ent;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign o_res_y   = w_head.y;
  assign o_res_ovf = w_head.ovf;
  assign o_res_unf = w_head.unf;
  assign o_res_tag = w_head.tag;

  assign o_busy = (r_inflight != '0) || (r_count != '0) || w_draining;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
module tb_fdiv_issue_ctrl;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic [TAG_W-1:0] req_tag;
  logic             div_valid;
  logic [31:0]      div_x1;
  logic [31:0]      div_x2;
  logic             div_out_valid;
  logic [31:0]      div_y;
  logic             div_ovf;
  logic             div_unf;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_y;
  logic             res_ovf;
  logic             res_unf;
  logic [TAG_W-1:0] res_tag;
  logic             busy;
  logic             err_sticky;

  always #5 clk = ~clk;

  fdiv_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_sys_clk      (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_x1       (req_x1),
    .i_req_x2       (req_x2),
    .i_req_tag      (req_tag),
    .o_div_valid    (div_valid),
    .o_div_x1       (div_x1),
    .o_div_x2       (div_x2),
    .i_div_out_valid(div_out_valid),
    .i_div_y        (div_y),
    .i_div_ovf      (div_ovf),
    .i_div_unf      (div_unf),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_y        (res_y),
    .o_res_ovf      (res_ovf),
    .o_res_unf      (res_unf),
    .o_res_tag      (res_tag),
    .o_busy         (busy),
    .o_err_sticky   (err_sticky)
  );

  // ---------------- arithmetic of the divider (normal operands) ----------------
  function automatic logic [63:0] s2d(input logic [31:0] a);
    if (a[30:23] == 8'd0) return {a[31], 63'd0};
    return {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'd0};
  endfunction

  // returns {y, ovf, unf}
  function automatic logic [33:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    real ra, rb, q;
    logic [63:0] qb;
    int e;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    if (rb == 0.0) return {a[31] ^ b[31], 8'hFF, 23'd0, 2'b10};
    q  = ra / rb;
    qb = $realtobits(q);
    e  = int'(qb[62:52]) - 1023 + 127;
    if (e > 254) return {qb[63], 8'hFF, 23'd0, 2'b10};
    if (e < 1)   return {qb[63], 31'd0, 2'b01};
    return {qb[63], e[7:0], qb[51:29], 2'b00};
  endfunction

  // ---------------- LAT-deep unit model, no reset, no stall ----------------
  logic [LAT-1:0] u_v = '0;
  logic [31:0]    u_x1 [LAT];
  logic [31:0]    u_x2 [LAT];
  logic           inj = 1'b0;

  always @(posedge clk) begin
    u_v     <= {u_v[LAT-2:0], div_valid};
    u_x1[0] <= div_x1;
    u_x2[0] <= div_x2;
    for (int k = 1; k < LAT; k++) begin
      u_x1[k] <= u_x1[k-1];
      u_x2[k] <= u_x2[k-1];
    end
  end

  assign div_out_valid = u_v[LAT-1] | inj;
  assign {div_y, div_ovf, div_unf} = fdiv_ref(u_x1[LAT-1], u_x2[LAT-1]);

  // ---------------- reference model and bookkeeping ----------------
  int checks    = 0;
  int failures  = 0;
  int cycles_hi = 0;   // consecutive cycles with reset released before this one
  int cyc       = 0;
  int nissues   = 0;
  int npops     = 0;
  bit exp_err   = 1'b0;
  logic [39:0]      exp_q[$];     // accepted, not yet consumed: {y, ovf, unf, tag}
  logic [TAG_W-1:0] got_tags[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Evaluate the current cycle against the model, then advance one clock.
  task automatic tick();
    bit iss;
    bit pop;
    logic [39:0] e;
    iss = (req_valid === 1'b1) && (req_ready === 1'b1);
    pop = (res_valid === 1'b1) && (res_ready === 1'b1) && (rst === 1'b1);
    if (rst === 1'b1) begin
      chk("req_ready", req_ready, (cycles_hi >= LAT) && (exp_q.size() < DEPTH));
      chk("busy", busy, (exp_q.size() != 0) || (cycles_hi < LAT));
      chk("err_sticky", err_sticky, exp_err);
      if (exp_q.size() == 0) chk("res_valid_empty", res_valid, 0);
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("pop_without_op", res_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {res_y, res_ovf, res_unf, res_tag}, e);
        got_tags.push_back(res_tag);
        npops++;
      end
    end
    if (iss) begin
      exp_q.push_back({fdiv_ref(req_x1, req_x2), req_tag});
      nissues++;
    end
    if (rst !== 1'b1) begin
      exp_q.delete();
      cycles_hi = 0;
    end else begin
      cycles_hi++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] m;
    int e;
    m = $urandom;
    e = $urandom_range(190, 60);
    return {m[31], e[7:0], m[22:0]};
  endfunction

  task automatic set_req(input bit v, input logic [TAG_W-1:0] tag);
    req_valid = v;
    req_x1    = rand_fp();
    req_x2    = rand_fp();
    req_tag   = tag;
  endtask

  task automatic wait_idle();
    int n = 0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_busy", busy, 0);
    chk("idle_res_valid", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int t0;
    int i0;
    int p0;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_x1    = '0;
    req_x2    = '0;
    req_tag   = '0;
    res_ready = 1'b0;

    // 1: drain window after reset release
    repeat (3) tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b1;
    set_req(1'b1, 6'd1);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t1_ready_delay", n, 5);
    tick();
    wait_idle();

    // 2: single op latency and value
    res_ready = 1'b1;
    req_valid = 1'b1;
    req_x1    = 32'h40C00000;
    req_x2    = 32'h40000000;
    req_tag   = 6'd3;
    chk("t2_ready", req_ready, 1);
    t0 = cyc;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t2_latency", cyc - t0, LAT + 1);
    chk("t2_y", res_y, 32'h40400000);
    chk("t2_tag", res_tag, 3);
    chk("t2_flags", {res_ovf, res_unf}, 0);
    wait_idle();

    // 3: credit limit with a stalled consumer
    res_ready = 1'b0;
    i0 = nissues;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, TAG_W'(i));
      tick();
    end
    req_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("t3_accepted", nissues - i0, DEPTH);
    chk("t3_ready_low", req_ready, 0);
    got_tags.delete();
    res_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("t3_returned", got_tags.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < got_tags.size(); k++) chk("t3_order", got_tags[k], k);
    wait_idle();

    // 4: full FIFO, steady pop + issue
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, TAG_W'(i + 16));
      tick();
    end
    req_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("t4_full_ready", req_ready, 0);
    chk("t4_full_valid", res_valid, 1);
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, TAG_W'($urandom));
      tick();
    end
    p0 = npops;
    i0 = nissues;
    for (int i = 0; i < 20; i++) begin
      set_req(1'b1, TAG_W'($urandom));
      tick();
    end
    chk("t4_pops", npops - p0, 20);
    chk("t4_issues", nissues - i0, 20);
    wait_idle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_req($urandom_range(3, 0) != 0, TAG_W'($urandom));
      res_ready = ($urandom_range(2, 0) != 0);
      tick();
    end
    wait_idle();

    // 5: reset with ops in flight; late unit outputs are ignored
    res_ready = 1'b1;
    i0 = nissues;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, TAG_W'(i + 40));
      tick();
    end
    chk("t5_issued", nissues - i0, 3);
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_ready_delay", n, 5);
    repeat (4) tick();
    chk("t5_res_valid", res_valid, 0);
    chk("t5_err", err_sticky, 0);
    wait_idle();

    // 6: spurious out_valid
    inj = 1'b1;
    tick();
    inj = 1'b0;
    exp_err = 1'b1;
    chk("t6_err", err_sticky, 1);
    chk("t6_res_valid", res_valid, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_err = 1'b0;
    repeat (LAT + 2) tick();
    chk("t6_err_cleared", err_sticky, 0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
